// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB NRZI transmit encoder: SYNC, bit stuffing, byte holding register and EOP
module usb_tx_encoder #(
   parameter int BIT_CLKS = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);
   localparam int TW = $clog2(BIT_CLKS);
   localparam logic [TW-1:0] TIMER_MAX = TW'(BIT_CLKS - 1);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
   state_t state, state_next;

   logic [TW-1:0] timer;
   logic [3:0]    left;
   logic [7:0]    shift;
   logic          cur_last;
   logic [7:0]    hold_data;
   logic          hold_last;
   logic          hold_full;
   logic [2:0]    ones;

   logic          wrap, boundary, stuff_now, go_eop, load, send;
   logic          transfer, start;
   logic [7:0]    sh_src;
   logic [3:0]    left_src;

   // left counts bits still owed in the current phase; a boundary is a wrap with nothing left
   always_comb begin
      wrap      = (state != IDLE) && (timer == TIMER_MAX);
      boundary  = wrap && (left == 4'd0) && (state == SYNC || state == DATA);
      stuff_now = (ones == 3'd6);
      go_eop    = boundary && (state == DATA) && (cur_last ? !stuff_now : !hold_full);
      load      = boundary && !cur_last && hold_full;
      send      = (boundary && !go_eop) || (state == DATA && wrap && left != 4'd0);
      sh_src    = load ? hold_data : shift;
      left_src  = load ? 4'd8 : left;
   end

   assign transfer = tx_valid && tx_ready;
   assign start    = (state == IDLE) && (transfer || hold_full);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SYNC;
         SYNC:    if (boundary) state_next = DATA;
         DATA:    if (go_eop) state_next = EOP_SE0;
         EOP_SE0: if (wrap && left == 4'd0) state_next = EOP_J;
         EOP_J:   if (wrap) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_busy  = (state != IDLE);
      tx_ready = (!hold_full || load) && (state != EOP_SE0) && (state != EOP_J);
      tx_done  = (state == EOP_J) && wrap;
      tx_error = go_eop && !cur_last;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         timer     <= '0;
         left      <= 4'd0;
         shift     <= 8'd0;
         cur_last  <= 1'b0;
         hold_data <= 8'd0;
         hold_last <= 1'b0;
         hold_full <= 1'b0;
         ones      <= 3'd0;
         d_plus    <= 1'b1;
         d_minus   <= 1'b0;
      end else begin
         if (state == IDLE || wrap) timer <= '0;
         else                       timer <= timer + TW'(1);

         if (transfer) begin
            hold_data <= tx_data;
            hold_last <= tx_last;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end

         // first SYNC bit is a 0, so the line leaves J for K immediately
         if (start) begin
            d_plus   <= 1'b0;
            d_minus  <= 1'b1;
            left     <= 4'd7;
            ones     <= 3'd0;
            cur_last <= 1'b0;
         end else if (state == SYNC && wrap && left != 4'd0) begin
            left <= left - 4'd1;
            if (left == 4'd1) begin
               ones <= 3'd1;
            end else begin
               d_plus  <= ~d_plus;
               d_minus <= ~d_minus;
            end
         end else if (send) begin
            if (load) cur_last <= hold_last;
            if (stuff_now) begin
               d_plus  <= ~d_plus;
               d_minus <= ~d_minus;
               ones    <= 3'd0;
               shift   <= sh_src;
               left    <= left_src;
            end else begin
               shift <= sh_src >> 1;
               left  <= left_src - 4'd1;
               if (sh_src[0]) begin
                  ones <= ones + 3'd1;
               end else begin
                  d_plus  <= ~d_plus;
                  d_minus <= ~d_minus;
                  ones    <= 3'd0;
               end
            end
         end else if (go_eop) begin
            d_plus  <= 1'b0;
            d_minus <= 1'b0;
            left    <= 4'd1;
         end else if (state == EOP_SE0 && wrap) begin
            if (left != 4'd0) begin
               left <= left - 4'd1;
            end else begin
               d_plus  <= 1'b1;
               d_minus <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001: Parameter BIT_CLKS, default 8, clk cycles per USB bit period (legal range 4..16).
REQ-002: clk  input  1  system clock; all logic on rising edge.
REQ-003: n_rst  input  1  reset, asynchronous, active-low.
REQ-004: tx_valid  input  1  tx_data/tx_last hold a byte offered for transmission.
REQ-005: tx_data  input  8  byte to send, LSB first.
REQ-006: tx_last  input  1  qualifies tx_data as the final byte of the packet.
REQ-007: tx_ready  output  1  block accepts the offered byte this cycle.
REQ-008: d_plus  output  1  registered USB D+ line drive.
REQ-009: d_minus  output  1  registered USB D- line drive.
REQ-010: tx_busy  output  1  high from packet start through end of EOP.
REQ-011: tx_done  output  1  one-cycle pulse on last cycle of EOP.
REQ-012: tx_error  output  1  one-cycle pulse on underrun detection.

Function
REQ-013: Byte transfer SHALL occur on a cycle where tx_valid & tx_ready; tx_data and tx_last latched that cycle.
REQ-014: One-byte holding register; tx_ready = holding register empty and not in EOP states.
REQ-015: States SHALL be IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-016: IDLE -> SYNC on a transfer; first SYNC bit driven on the next cycle.
REQ-017: Bit timer counts 0..BIT_CLKS-1; line outputs change only at timer wrap (bit boundary); each bit lasts exactly BIT_CLKS cycles.
REQ-018: SYNC sends pattern 8'h80 LSB first (seven 0s then 1), then DATA.
REQ-019: DATA moves holding register into shift register at each byte boundary, freeing holding register; back-to-back bytes SHALL have no gap bits.
REQ-020: NRZI: bit 0 toggles line state, bit 1 holds; J = (d_plus 1, d_minus 0), K = (0,1); idle and post-reset state is J.
REQ-021: Ones counter counts consecutive 1 bits sent, including SYNC's final 1; at count 6 a stuff 0 bit is inserted next and counter clears; any 0 clears counter.
REQ-022: A stuff bit owed after the final data bit SHALL be sent before EOP.
REQ-023: After final bit of a byte flagged tx_last (plus any stuff bit) -> EOP_SE0: d_plus=0, d_minus=0 for 2 bit periods.
REQ-024: EOP_J drives J for 1 bit period; tx_done pulses on its last cycle; then IDLE with tx_busy=0.
REQ-025: Underrun: at a byte boundary in DATA with holding register empty and no tx_last seen -> tx_error pulse same cycle, go to EOP_SE0 (pending stuff bit dropped).
REQ-026: tx_ready low during EOP_SE0/EOP_J; bytes offered then are not accepted.
REQ-027: Transfer and shift-register load on same cycle permitted; the new byte SHALL enter the holding register.

Reset
REQ-028: n_rst low SHALL immediately force IDLE, d_plus=1, d_minus=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, counters and registers cleared, NRZI state J.
REQ-029: Reset mid-packet aborts without EOP; first packet after release starts clean with SYNC.

Verification
REQ-030: Reset -> d_plus=1, d_minus=0, tx_ready=1, tx_busy=0 immediately, before any clk edge.
REQ-031: BIT_CLKS=8, one byte 8'h00 tx_last=1 -> line K J K J K J K K (SYNC), J K J K J K J K, SE0 x2, J; tx_done at cycle 152 after transfer; no stuff bits.
REQ-032: Byte 8'hFF tx_last=1 -> after SYNC, K held 5 bits, stuff bit to J, J held 3 bits, SE0 x2, J; total 20 bit periods (160 cycles).
REQ-033: Bytes 8'hA5 then 8'h3C (tx_last on second), tx_valid held -> second transfer during first byte, bits contiguous 10100101 then 00111100 LSB-first, single EOP, one tx_done.
REQ-034: Byte 8'h12 tx_last=0, tx_valid then low -> after SYNC+8 bits tx_error pulses once, SE0 x2, J, tx_done, tx_ready=1 in IDLE.
REQ-035: n_rst asserted mid-DATA -> lines J same cycle, tx_busy=0, no tx_done; next packet 8'h00 reproduces REQ-031 waveform exactly.
